// File: rtl/mod_mult_seq.sv
// mod_mult_seq -- sequential modular multiplier, product = (x * y) mod m.
//
// Interleaved (MSB-first) shift-and-add with one multiplier bit retired per
// clock.  Every step keeps the accumulator reduced below m, so an operation
// takes exactly WIDTH cycles in CALC.  Optional range checking rejects
// operands that break the acc < m invariant (x >= m, y >= m, m < 2) and
// reports them through err with a zero product.
//
// Parameters
//   WIDTH       operand / modulus / result width in bits (4..512)
//   CHECK_RANGE 1 enables the operand range check at acceptance
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   x, y and m are valid this cycle
//   in_ready   block can accept an operation (state IDLE)
//   x, y, m    multiplicand, multiplier, modulus (latched at acceptance)
//   out_valid  product and err are valid (state DONE)
//   out_ready  consumer accepts the result
//   product    (x * y) mod m, held until the next result is produced
//   err        operands were out of range; product is forced to 0
module mod_mult_seq #(
  parameter int WIDTH       = 256,
  parameter int CHECK_RANGE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] xr, yr, mr;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    i;
  logic             accept;
  logic             range_bad;
  logic             last_bit;

  // Doubling modulo md; a < md guarantees a single conditional subtract
  // suffices.  The extra top bit absorbs the carry out of the shift.
  function automatic logic [WIDTH-1:0] mod_dbl(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] md);
    logic [WIDTH:0] t;
    t = {a, 1'b0};
    if (t >= {1'b0, md}) t = t - {1'b0, md};
    return t[WIDTH-1:0];
  endfunction

  // Addition modulo md for a, b < md; one conditional subtract suffices.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] md);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= {1'b0, md}) t = t - {1'b0, md};
    return t[WIDTH-1:0];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign last_bit  = (i == '0);

  // m < 2 is equivalent to every bit above bit 0 being clear.
  assign range_bad = (CHECK_RANGE != 0) &&
                     ((x >= m) || (y >= m) || (m[WIDTH-1:1] == '0));

  always_comb begin
    acc_nxt = mod_dbl(acc, mr);
    if (yr[i]) acc_nxt = mod_add(acc_nxt, xr, mr);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = range_bad ? DONE : CALC;
      CALC: if (last_bit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      xr <= x;
      yr <= y;
      mr <= m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      i       <= '0;
      product <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (range_bad) begin
              product <= '0;
              err     <= 1'b1;
            end else begin
              acc <= '0;
              i   <= CW'(WIDTH - 1);
              err <= 1'b0;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          // Decrement wraps below zero only on the final bit, as CALC exits.
          i   <= i - 1'b1;
          if (last_bit) product <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_seq.sv
// Testbench for mod_mult_seq: an 8-bit and a 256-bit instance share one
// clock; expected results are queued when an operation is issued and
// popped when out_valid appears.
module tb_mod_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst8, iv8, ir8, ov8, or8, e8;
  logic [7:0]   x8, y8, m8, p8;
  logic         rst256, iv256, ir256, ov256, or256, e256;
  logic [255:0] x256, y256, m256, p256;

  mod_mult_seq #(.WIDTH(8), .CHECK_RANGE(1)) u8 (
    .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .m(m8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .err(e8));

  mod_mult_seq #(.WIDTH(256), .CHECK_RANGE(1)) u256 (
    .clk(clk), .reset(rst256), .in_valid(iv256), .in_ready(ir256),
    .x(x256), .y(y256), .m(m256), .out_valid(ov256), .out_ready(or256),
    .product(p256), .err(e256));

  typedef struct {
    logic [255:0] prod;
    logic         err;
    int           lat;
  } exp_t;

  exp_t q8[$];
  exp_t q256[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [255:0] SECP_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] md);
    logic [15:0] t;
    t = {8'd0, a} * {8'd0, b};
    t = t % {8'd0, md};
    return t[7:0];
  endfunction

  function automatic logic [255:0] ref256(input logic [255:0] a,
                                          input logic [255:0] b,
                                          input logic [255:0] md);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, md};
    return t[255:0];
  endfunction

  // Issue one 8-bit operation, check latency/result, optionally hold the
  // result under backpressure, then release it.  busy_iv keeps in_valid
  // high with junk operands while the block is busy.
  task automatic run8(input logic [7:0] xi, input logic [7:0] yi,
                      input logic [7:0] mi, input logic [7:0] pexp,
                      input logic eexp, input int hold, input bit busy_iv);
    exp_t e;
    int   cnt;
    bit   stable;
    e.prod = {248'd0, pexp};
    e.err  = eexp;
    e.lat  = eexp ? 0 : 8;   // error result is visible in the cycle right after accept
    q8.push_back(e);
    cnt = 0;
    while (ir8 !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    vectors++;
    if (ir8 !== 1'b1) begin
      miscompares++;
      $display("FAIL run8_ready got=%b want=1", ir8);
    end
    x8 = xi; y8 = yi; m8 = mi; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = busy_iv;
    x8 = 8'($urandom); y8 = 8'($urandom); m8 = 8'($urandom);
    cnt = 0;
    while (ov8 !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    e = q8.pop_front();
    vectors++;
    if (ov8 !== 1'b1 || cnt != e.lat) begin
      miscompares++;
      $display("FAIL run8_latency x=%0d y=%0d m=%0d got=%0d ov=%b want=%0d",
               xi, yi, mi, cnt, ov8, e.lat);
    end
    vectors++;
    if (p8 !== e.prod[7:0] || e8 !== e.err) begin
      miscompares++;
      $display("FAIL run8_result x=%0d y=%0d m=%0d got=%0d/err%b want=%0d/err%b",
               xi, yi, mi, p8, e8, e.prod[7:0], e.err);
    end
    iv8 = 1'b0;
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        if (p8 !== e.prod[7:0] || e8 !== e.err || ov8 !== 1'b1 || ir8 !== 1'b0)
          stable = 1'b0;
      end
      vectors++;
      if (!stable) begin
        miscompares++;
        $display("FAIL run8_hold got p=%0d ov=%b ir=%b want p=%0d ov=1 ir=0",
                 p8, ov8, ir8, e.prod[7:0]);
      end
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    vectors++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      miscompares++;
      $display("FAIL run8_release got ir=%b ov=%b want ir=1 ov=0", ir8, ov8);
    end
  endtask

  task automatic run256(input logic [255:0] xi, input logic [255:0] yi,
                        input logic [255:0] mi, input logic [255:0] pexp);
    exp_t e;
    int   cnt;
    e.prod = pexp; e.err = 1'b0; e.lat = 256;
    q256.push_back(e);
    cnt = 0;
    while (ir256 !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    x256 = xi; y256 = yi; m256 = mi; iv256 = 1'b1;
    @(posedge clk); #1;
    iv256 = 1'b0; x256 = '0; y256 = '0; m256 = '0;
    cnt = 0;
    while (ov256 !== 1'b1 && cnt < 300) begin @(posedge clk); #1; cnt++; end
    e = q256.pop_front();
    vectors++;
    if (ov256 !== 1'b1 || cnt != e.lat) begin
      miscompares++;
      $display("FAIL run256_latency got=%0d ov=%b want=%0d", cnt, ov256, e.lat);
    end
    vectors++;
    if (p256 !== e.prod || e256 !== e.err) begin
      miscompares++;
      $display("FAIL run256_result got=%h/err%b want=%h/err0", p256, e256, e.prod);
    end
    or256 = 1'b1;
    @(posedge clk); #1;
    or256 = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 8'd0 || e8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8 got ir=%b ov=%b p=%0d err=%b want 1/0/0/0", ir8, ov8, p8, e8);
    end
    vectors++;
    if (ir256 !== 1'b1 || ov256 !== 1'b0 || p256 !== '0 || e256 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset256 got ir=%b ov=%b err=%b want 1/0/0", ir256, ov256, e256);
    end
    @(posedge clk); #3;
    rst8 = 1'b1; rst256 = 1'b1;
  endtask

  task automatic test_spec8;
    run8(8'd200, 8'd150, 8'd251, 8'd131, 1'b0, 0, 1'b0);
    run8(8'd12,  8'd12,  8'd13,  8'd1,   1'b0, 0, 1'b0);
    run8(8'd0,   8'd77,  8'd251, 8'd0,   1'b0, 0, 1'b0);
    run8(8'd250, 8'd250, 8'd251, 8'd1,   1'b0, 0, 1'b0);
  endtask

  task automatic test_range_err8;
    run8(8'd251, 8'd5,   8'd251, 8'd0, 1'b1, 0, 1'b0);
    run8(8'd3,   8'd13,  8'd13,  8'd0, 1'b1, 0, 1'b0);
    run8(8'd0,   8'd0,   8'd1,   8'd0, 1'b1, 0, 1'b0);
    run8(8'd0,   8'd0,   8'd0,   8'd0, 1'b1, 0, 1'b0);
    // Smallest legal modulus after an error: err must clear.
    run8(8'd1,   8'd1,   8'd2,   8'd1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random8;
    logic [7:0] mm, xx, yy;
    for (int k = 0; k < 8; k++) begin
      mm = 8'($urandom_range(2, 255));
      xx = 8'($urandom_range(0, int'(mm) - 1));
      yy = 8'($urandom_range(0, int'(mm) - 1));
      run8(xx, yy, mm, ref8(xx, yy, mm), 1'b0, 0, 1'b0);
    end
  endtask

  task automatic test_backpressure;
    run8(8'd200, 8'd150, 8'd251, 8'd131, 1'b0, 20, 1'b0);
    run8(8'd7,   8'd9,   8'd10,  8'd3,   1'b0, 0,  1'b0);
  endtask

  task automatic test_ignore_busy;
    run8(8'd100, 8'd99, 8'd101, ref8(8'd100, 8'd99, 8'd101), 1'b0, 3, 1'b1);
    run8(8'd5, 8'd5, 8'd7, 8'd4, 1'b1 ^ 1'b1, 0, 1'b1);
  endtask

  task automatic test_done_reset8;
    int cnt;
    bit quiet;
    x8 = 8'd3; y8 = 8'd4; m8 = 8'd13; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    cnt = 0;
    while (ov8 !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    vectors++;
    if (p8 !== 8'd12 || ov8 !== 1'b1) begin
      miscompares++;
      $display("FAIL done_reset_pre got p=%0d ov=%b want 12/1", p8, ov8);
    end
    #2 rst8 = 1'b0;
    #1;
    vectors++;
    if (ov8 !== 1'b0 || p8 !== 8'd0 || e8 !== 1'b0 || ir8 !== 1'b1) begin
      miscompares++;
      $display("FAIL done_reset got ov=%b p=%0d err=%b ir=%b want 0/0/0/1", ov8, p8, e8, ir8);
    end
    @(posedge clk); @(posedge clk); #3;
    rst8 = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL done_reset_quiet got out_valid pulse want none");
    end
  endtask

  task automatic test_secp256k1;
    logic [255:0] r;
    run256(SECP_P - 256'd1, SECP_P - 256'd1, SECP_P, 256'd1);
    run256(256'd2, (SECP_P + 256'd1) >> 1, SECP_P, 256'd1);
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    r = r % SECP_P;
    run256(r, SECP_P - 256'd2, SECP_P, ref256(r, SECP_P - 256'd2, SECP_P));
  endtask

  task automatic test_reset_mid_calc;
    exp_t e;
    int   cnt;
    e.prod = 256'd1; e.err = 1'b0; e.lat = 256;
    q256.push_back(e);
    x256 = SECP_P - 256'd1; y256 = SECP_P - 256'd1; m256 = SECP_P; iv256 = 1'b1;
    @(posedge clk); #1;
    iv256 = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst256 = 1'b0;
    #1;
    q256.delete();
    vectors++;
    if (p256 !== '0 || e256 !== 1'b0 || ov256 !== 1'b0 || ir256 !== 1'b1) begin
      miscompares++;
      $display("FAIL calc_reset got ov=%b err=%b ir=%b nonzero_p=%b want 0/0/1/0",
               ov256, e256, ir256, |p256);
    end
    // Fresh operation presented while reset is still low; it must be taken
    // on the first rising edge after release.
    e.prod = ref256(256'd12345, 256'd67890, SECP_P); e.err = 1'b0; e.lat = 256;
    q256.push_back(e);
    x256 = 256'd12345; y256 = 256'd67890; m256 = SECP_P; iv256 = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rst256 = 1'b1;
    @(posedge clk); #1;
    iv256 = 1'b0;
    vectors++;
    if (ir256 !== 1'b0) begin
      miscompares++;
      $display("FAIL first_edge_accept got ir=%b want 0", ir256);
    end
    cnt = 0;
    while (ov256 !== 1'b1 && cnt < 300) begin @(posedge clk); #1; cnt++; end
    e = q256.pop_front();
    vectors++;
    if (ov256 !== 1'b1 || cnt != e.lat || p256 !== e.prod) begin
      miscompares++;
      $display("FAIL after_reset got lat=%0d p=%h want lat=%0d p=%h", cnt, p256, e.lat, e.prod);
    end
    or256 = 1'b1;
    @(posedge clk); #1;
    or256 = 1'b0;
  endtask

  initial begin
    rst8 = 1'b0; iv8 = 1'b0; or8 = 1'b0; x8 = '0; y8 = '0; m8 = '0;
    rst256 = 1'b0; iv256 = 1'b0; or256 = 1'b0; x256 = '0; y256 = '0; m256 = '0;
    test_reset;
    test_spec8;
    test_range_err8;
    test_random8;
    test_backpressure;
    test_ignore_busy;
    test_done_reset8;
    test_secp256k1;
    test_reset_mid_calc;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
